clarvi_uop_sequencer: RTL and testbench
=======================================

// Module: clarvi_uop_sequencer
// PURPOSE
// - Splits each decoded RV64 instruction into two 32-bit micro-ops for the 32-bit execute ALU. Sits between decode/register-read and execute.
// - Sets instr_part, selects the matching 32-bit operand halves and orders the parts so the ALU carry/compare/shift state (ex_state) flows in the right direction.
// - Holds execute at a throughput of one instruction every 2 cycles.
// PARAMETERS
// - PERF_W  32  width of the issued-micro-op counter (used only with CLARVI_UOP_PERF_EN).
// PORTS
// - clock           in   1       core clock
// - reset           in   1       asynchronous, active-high
// - flush           in   1       synchronous kill of the held instruction
// - stall           in   1       execute stall; output is frozen while high
// - in_valid        in   1       decoded instruction available
// - in_ready        out  1       sequencer accepts in_* this cycle
// - in_instr        in   instr_t decoded instruction (instr_part ignored)
// - in_rs1, in_rs2  in   64      full register operands
// - uop_valid       out  1       micro-op presented to execute
// - uop_instr       out  instr_t in_instr with instr_part and immediate rewritten
// - uop_rs1_value   out  32      rs1 half for this part
// - uop_rs2_value   out  32      rs2 half for this part
// - uop_first       out  1       first micro-op of the instruction
// - uop_last        out  1       second micro-op; the instruction retires on it
// - perf_uop_count  out  PERF_W  only with CLARVI_UOP_PERF_EN
// BEHAVIOUR
// - FSM states: IDLE, PART_A, PART_B. All outputs are registered.
// - Reset is async; flops reset to: IDLE, uop_valid=0, uop_first=0, uop_last=0, uop_instr='0, uop_rs*=0, counter=0.
// - in_ready = (state==IDLE) | (state==PART_B & !stall).
// - Accept: in_valid & in_ready latches instr, rs1 and rs2. Next state is PART_A, so latency is 1 cycle.
// - PART_A and !stall: go to PART_B. PART_B and !stall: go to PART_A if a new instruction is accepted, else IDLE.
// - Stall holds state and every output bit-for-bit.
// - Part order:
//   - Upper half first (PART_A gets part 1): SLT, SLTU, SRL, SRA with is32_bit_op=0.
//   - All other ops, including every is32_bit_op op: part 0 in PART_A, part 1 in PART_B.
// - Operand halves: part 0 uses rs1[31:0] and rs2[31:0]; part 1 uses rs1[63:32] and rs2[63:32].
// - Shift exception: for SL, SRL and SRA, uop_rs2_value is rs2[31:0] in both parts, because the shift amount lives in the low bits.
// - Immediate, part 0: passed unchanged.
// - Immediate, part 1:
//   - SL, SRL, SRA: passed unchanged.
//   - All other ops: {32{imm[31]}}, i.e. the sign extension of the immediate.
// - uop_first=1 in PART_A and 0 in PART_B; uop_last is the inverse. Both are 0 in IDLE.
// - Flush:
//   - Next edge goes to IDLE with uop_valid=0, even if stall is high.
//   - in_ready is forced 0 during a flush cycle.
//   - Flush takes priority over an accept.
// - Back-to-back: PART_B completing in the same cycle as an accept gives no bubble, so the pattern is A,B,A,B.
// - in_valid low in PART_B: uop_valid=0 on the following cycle.
// - Any opcode outside the defined set is treated like ADD for ordering. Its data is don't-care.
// CONFIGURATION
// - CLARVI_UOP_PERF_EN defined:
//   - perf_uop_count increments once per micro-op leaving the output (uop_valid & !stall).
//   - The counter wraps modulo 2^PERF_W and is cleared only by reset.
// - CLARVI_UOP_PERF_EN undefined: the port and counter are absent, with zero area.
// TESTING
// - ADD, rs1=64'h0000_0001_FFFF_FFFF, rs2=1:
//   - cycle+1: part0, rs1=FFFF_FFFF, rs2=1, first=1.
//   - cycle+2: part1, rs1=1, rs2=0, last=1.
// - SLTU, rs1=64'h5_0000_0000, rs2=64'h5_0000_0001: part1 is issued first (rs1=5, rs2=5), then part0 (rs1=0, rs2=1).
// - SRAI by 40, imm=40: both parts show immediate=40 and rs2 half = rs2[31:0]. Order is part1, then part0.
// - ADDI imm=32'hFFFF_FFF0: part0 immediate=FFFF_FFF0, part1 immediate=FFFF_FFFF. Same with imm=32'h10: part1 immediate=0.
// - Stall held 3 cycles in PART_A: outputs are unchanged and in_ready=0. After release, PART_B follows and then a queued instruction is issued with no bubble.
// - Flush in PART_A with stall=1: next cycle uop_valid=0, state is IDLE, in_ready=1. Async reset mid-PART_B clears all outputs immediately.
// - With CLARVI_UOP_PERF_EN: 3 back-to-back instructions give perf_uop_count=6. With PERF_W=2, the count wraps to 2.

Source files
------------

// File: rtl/clarvi_uop_sequencer_pkg.sv
// Shared types for the CLARVI micro-op sequencer: the decoded instruction
// record that travels from decode to execute, the ALU op codes the sequencer
// cares about, and the sequencer state encoding (visible on its debug port).
package clarvi_uop_sequencer_pkg;

  // ALU operation codes. Codes 10..15 are unused by the core and are ordered
  // like ADD.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SL   = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  // Decoded instruction. instr_part selects which 32-bit half execute works on.
  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        is32_bit_op;
    logic        instr_part;
    logic [31:0] immediate;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PART_A = 2'd1,
    PART_B = 2'd2
  } seq_state_t;

endpackage

// File: rtl/clarvi_uop_sequencer_if.sv
// Decode-to-execute link through the micro-op sequencer.
// Handshake: an instruction transfers on a clock edge where in_valid and
// in_ready are both high; in_valid may not depend on in_ready. On the
// execute side a micro-op leaves on an edge where uop_valid is high and
// stall is low; while stall is high every uop_* signal is held. flush kills
// whatever the sequencer holds on the next edge.
// slave modport = sequencer, master modport = surrounding pipeline.
interface clarvi_uop_sequencer_if;
  import clarvi_uop_sequencer_pkg::*;

  logic        flush;
  logic        stall;
  logic        in_valid;
  logic        in_ready;
  instr_t      in_instr;
  logic [63:0] in_rs1;
  logic [63:0] in_rs2;
  logic        uop_valid;
  instr_t      uop_instr;
  logic [31:0] uop_rs1_value;
  logic [31:0] uop_rs2_value;
  logic        uop_first;
  logic        uop_last;

  modport master (
    output flush, stall, in_valid, in_instr, in_rs1, in_rs2,
    input  in_ready, uop_valid, uop_instr, uop_rs1_value, uop_rs2_value,
           uop_first, uop_last
  );

  modport slave (
    input  flush, stall, in_valid, in_instr, in_rs1, in_rs2,
    output in_ready, uop_valid, uop_instr, uop_rs1_value, uop_rs2_value,
           uop_first, uop_last
  );

endinterface

// File: rtl/clarvi_uop_sequencer.sv
// clarvi_uop_sequencer: splits each decoded RV64 instruction into two 32-bit
// micro-ops for the 32-bit execute ALU, one instruction every two cycles.
// Compares and right shifts issue the upper half first so the ALU carry /
// compare / shift state flows from high word to low word; everything else
// issues the low half first.
// Optional feature: define CLARVI_UOP_PERF_EN to add the perf_uop_count port
// and its PERF_W-bit issued-micro-op counter.
module clarvi_uop_sequencer
  import clarvi_uop_sequencer_pkg::*;
`ifdef CLARVI_UOP_PERF_EN
#(
  parameter int PERF_W = 32
)
`endif
(
  input  logic                         clock,
  input  logic                         reset,
  clarvi_uop_sequencer_if.slave        bus,
  output seq_state_t                   fsm_state
`ifdef CLARVI_UOP_PERF_EN
  ,
  output logic [PERF_W-1:0]            perf_uop_count
`endif
);

  // Ops whose 64-bit result depends on the upper word being processed first.
  function automatic logic upper_first(input instr_t i);
    return !i.is32_bit_op &&
           (i.op == OP_SLT || i.op == OP_SLTU || i.op == OP_SRL || i.op == OP_SRA);
  endfunction

  // Shifts keep the shift amount (low rs2 word) and the immediate in both parts.
  function automatic logic is_shift(input instr_t i);
    return i.op == OP_SL || i.op == OP_SRL || i.op == OP_SRA;
  endfunction

  seq_state_t  state, state_next;
  instr_t      held_instr;
  logic [63:0] held_rs1, held_rs2;

  logic        accept;
  logic        data_load;
  logic        valid_next, first_next, last_next;
  instr_t      src_instr, instr_next;
  logic [63:0] src_rs1, src_rs2;
  logic        src_part;
  logic [31:0] rs1_next, rs2_next;

  assign fsm_state    = state;
  assign bus.in_ready = !bus.flush &&
                        ((state == IDLE) || (state == PART_B && !bus.stall));
  assign accept       = bus.in_valid && bus.in_ready;

  // Next state and next values of the registered outputs.
  always_comb begin
    state_next = state;
    valid_next = bus.uop_valid;
    first_next = bus.uop_first;
    last_next  = bus.uop_last;
    data_load  = 1'b0;

    if (bus.flush) begin
      state_next = IDLE;
      valid_next = 1'b0;
      first_next = 1'b0;
      last_next  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state_next = PART_A;
            valid_next = 1'b1;
            first_next = 1'b1;
            last_next  = 1'b0;
            data_load  = 1'b1;
          end else begin
            valid_next = 1'b0;
            first_next = 1'b0;
            last_next  = 1'b0;
          end
        end
        PART_A: begin
          if (!bus.stall) begin
            state_next = PART_B;
            valid_next = 1'b1;
            first_next = 1'b0;
            last_next  = 1'b1;
            data_load  = 1'b1;
          end
        end
        PART_B: begin
          if (!bus.stall) begin
            if (accept) begin
              state_next = PART_A;
              valid_next = 1'b1;
              first_next = 1'b1;
              last_next  = 1'b0;
              data_load  = 1'b1;
            end else begin
              state_next = IDLE;
              valid_next = 1'b0;
              first_next = 1'b0;
              last_next  = 1'b0;
            end
          end
        end
        default: begin
          state_next = IDLE;
          valid_next = 1'b0;
          first_next = 1'b0;
          last_next  = 1'b0;
        end
      endcase
    end
  end

  // Micro-op payload: a fresh instruction starts its first part, otherwise the
  // held instruction issues its second part.
  always_comb begin
    src_instr = accept ? bus.in_instr : held_instr;
    src_rs1   = accept ? bus.in_rs1   : held_rs1;
    src_rs2   = accept ? bus.in_rs2   : held_rs2;
    src_part  = accept ? upper_first(src_instr) : !upper_first(src_instr);

    rs1_next  = src_part ? src_rs1[63:32] : src_rs1[31:0];
    rs2_next  = (src_part && !is_shift(src_instr)) ? src_rs2[63:32] : src_rs2[31:0];

    instr_next            = src_instr;
    instr_next.instr_part = src_part;
    if (src_part && !is_shift(src_instr)) begin
      instr_next.immediate = {32{src_instr.immediate[31]}};
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered outputs and the held copy of the accepted instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.uop_valid     <= 1'b0;
      bus.uop_first     <= 1'b0;
      bus.uop_last      <= 1'b0;
      bus.uop_instr     <= '0;
      bus.uop_rs1_value <= '0;
      bus.uop_rs2_value <= '0;
      held_instr        <= '0;
      held_rs1          <= '0;
      held_rs2          <= '0;
    end else begin
      bus.uop_valid <= valid_next;
      bus.uop_first <= first_next;
      bus.uop_last  <= last_next;
      if (data_load) begin
        bus.uop_instr     <= instr_next;
        bus.uop_rs1_value <= rs1_next;
        bus.uop_rs2_value <= rs2_next;
      end
      if (accept) begin
        held_instr <= bus.in_instr;
        held_rs1   <= bus.in_rs1;
        held_rs2   <= bus.in_rs2;
      end
    end
  end

`ifdef CLARVI_UOP_PERF_EN
  // Count micro-ops leaving toward execute; wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_uop_count <= '0;
    end else if (bus.uop_valid && !bus.stall) begin
      perf_uop_count <= perf_uop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_clarvi_uop_sequencer.sv
// Testbench for clarvi_uop_sequencer: directed cases for the documented
// examples followed by randomized traffic, all checked against a queue-based
// reference model of the issued micro-op stream.
module tb_clarvi_uop_sequencer;
  import clarvi_uop_sequencer_pkg::*;

  typedef struct {
    instr_t      instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        first;
    logic        last;
  } uop_t;

  logic       clock;
  logic       reset;
  seq_state_t fsm_state;
`ifdef CLARVI_UOP_PERF_EN
  logic [31:0] perf_uop_count;
`endif

  clarvi_uop_sequencer_if bus();

`ifdef CLARVI_UOP_PERF_EN
  clarvi_uop_sequencer #(.PERF_W(32)) dut (
    .clock(clock), .reset(reset), .bus(bus), .fsm_state(fsm_state),
    .perf_uop_count(perf_uop_count)
  );
`else
  clarvi_uop_sequencer dut (
    .clock(clock), .reset(reset), .bus(bus), .fsm_state(fsm_state)
  );
`endif

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the micro-op currently on the output plus the queue of
  // micro-ops still owed for the instruction in flight.
  logic        m_cur_valid = 1'b0;
  uop_t        m_cur;
  uop_t        m_pend[$];
  logic [31:0] m_count = '0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expand one instruction into its two micro-ops in issue order.
  function automatic void model_expand(input instr_t ins, input logic [63:0] a,
                                       input logic [63:0] b);
    uop_t u;
    bit   hi_first;
    bit   shift;
    int   part;
    hi_first = !ins.is32_bit_op &&
               (ins.op inside {OP_SLT, OP_SLTU, OP_SRL, OP_SRA});
    shift    = ins.op inside {OP_SL, OP_SRL, OP_SRA};
    for (int k = 0; k < 2; k++) begin
      part = hi_first ? 1 - k : k;
      u.instr            = ins;
      u.instr.instr_part = (part == 1);
      u.rs1              = 32'(a >> (32 * part));
      u.rs2              = shift ? b[31:0] : 32'(b >> (32 * part));
      if (part == 1 && !shift) u.instr.immediate = ins.immediate[31] ? 32'hFFFF_FFFF : 32'h0;
      u.first = (k == 0);
      u.last  = (k == 1);
      m_pend.push_back(u);
    end
  endfunction

  task automatic model_reset();
    m_cur_valid = 1'b0;
    m_pend.delete();
    m_count = '0;
  endtask

  // Compare the registered outputs with the model's current micro-op.
  task automatic check_outputs();
    check_val("uop_valid", 64'(bus.uop_valid), 64'(m_cur_valid));
    if (m_cur_valid) begin
      check_val("uop_instr", 64'(bus.uop_instr), 64'(m_cur.instr));
      check_val("uop_rs1", 64'(bus.uop_rs1_value), 64'(m_cur.rs1));
      check_val("uop_rs2", 64'(bus.uop_rs2_value), 64'(m_cur.rs2));
      check_val("uop_first", 64'(bus.uop_first), 64'(m_cur.first));
      check_val("uop_last", 64'(bus.uop_last), 64'(m_cur.last));
    end else begin
      check_val("idle_first", 64'(bus.uop_first), 64'd0);
      check_val("idle_last", 64'(bus.uop_last), 64'd0);
      check_val("idle_state", 64'(fsm_state), 64'(IDLE));
    end
`ifdef CLARVI_UOP_PERF_EN
    check_val("perf_count", 64'(perf_uop_count), 64'(m_count));
`endif
  endtask

  // Driver: one clock cycle of inputs, checked against the model.
  task automatic cycle(input logic v, input instr_t ins, input logic [63:0] a,
                       input logic [63:0] b, input logic st, input logic fl);
    logic rdy;
    @(negedge clock);
    check_outputs();
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.stall    = st;
    bus.flush    = fl;
    #1;
    rdy = !fl && (!m_cur_valid || (m_pend.size() == 0 && !st));
    check_val("in_ready", 64'(bus.in_ready), 64'(rdy));
    if (m_cur_valid && !st) m_count++;
    if (fl) begin
      m_cur_valid = 1'b0;
      m_pend.delete();
    end else if (!(m_cur_valid && st)) begin
      if (v && rdy) model_expand(ins, a, b);
      if (m_pend.size() > 0) begin
        m_cur       = m_pend.pop_front();
        m_cur_valid = 1'b1;
      end else begin
        m_cur_valid = 1'b0;
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, '0, 64'd0, 64'd0, 1'b0, 1'b0);
  endtask

  // Literal check of the micro-op produced by the edge following cycle().
  task automatic expect_uop(input string tag, input logic part,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] imm, input logic first);
    @(posedge clock);
    #1;
    check_val({tag, ".valid"}, 64'(bus.uop_valid), 64'd1);
    check_val({tag, ".part"}, 64'(bus.uop_instr.instr_part), 64'(part));
    check_val({tag, ".rs1"}, 64'(bus.uop_rs1_value), 64'(r1));
    check_val({tag, ".rs2"}, 64'(bus.uop_rs2_value), 64'(r2));
    check_val({tag, ".imm"}, 64'(bus.uop_instr.immediate), 64'(imm));
    check_val({tag, ".first"}, 64'(bus.uop_first), 64'(first));
    check_val({tag, ".last"}, 64'(bus.uop_last), 64'(!first));
  endtask

  function automatic instr_t mk(input logic [3:0] op, input logic is32,
                                input logic [31:0] imm);
    instr_t i;
    i.op          = op;
    i.rd          = 5'($urandom_range(0, 31));
    i.is32_bit_op = is32;
    i.instr_part  = 1'($urandom_range(0, 1));
    i.immediate   = imm;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    logic [31:0] imm;
    imm = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
    return mk(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0), imm);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".valid"}, 64'(bus.uop_valid), 64'd0);
    check_val({tag, ".first"}, 64'(bus.uop_first), 64'd0);
    check_val({tag, ".last"}, 64'(bus.uop_last), 64'd0);
    check_val({tag, ".instr"}, 64'(bus.uop_instr), 64'd0);
    check_val({tag, ".rs1"}, 64'(bus.uop_rs1_value), 64'd0);
    check_val({tag, ".rs2"}, 64'(bus.uop_rs2_value), 64'd0);
    check_val({tag, ".state"}, 64'(fsm_state), 64'(IDLE));
  endtask

  initial begin
    instr_t i1, i2;
    logic   v, st, fl;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_rs1   = '0;
    bus.in_rs2   = '0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    #2 reset = 1'b0;
    model_reset();

    // ADD with carry out of the low word.
    cycle(1'b1, mk(OP_ADD, 1'b0, 32'd0), 64'h0000_0001_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    expect_uop("add_p0", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    idle();
    expect_uop("add_p1", 1'b1, 32'd1, 32'd0, 32'd0, 1'b0);
    idle();

    // SLTU issues the upper half first.
    cycle(1'b1, mk(OP_SLTU, 1'b0, 32'd0), 64'h5_0000_0000, 64'h5_0000_0001, 1'b0, 1'b0);
    expect_uop("sltu_p1", 1'b1, 32'd5, 32'd5, 32'd0, 1'b1);
    idle();
    expect_uop("sltu_p0", 1'b0, 32'd0, 32'd1, 32'd0, 1'b0);
    idle();

    // SRAI by 40: shift amount and immediate unchanged in both parts.
    cycle(1'b1, mk(OP_SRA, 1'b0, 32'd40), 64'h8765_4321_0000_1111,
          64'h1234_5678_0000_0028, 1'b0, 1'b0);
    expect_uop("srai_p1", 1'b1, 32'h8765_4321, 32'h0000_0028, 32'd40, 1'b1);
    idle();
    expect_uop("srai_p0", 1'b0, 32'h0000_1111, 32'h0000_0028, 32'd40, 1'b0);
    idle();

    // ADDI immediate sign extension into the upper part.
    cycle(1'b1, mk(OP_ADD, 1'b0, 32'hFFFF_FFF0), 64'd7, 64'd0, 1'b0, 1'b0);
    expect_uop("addi_neg_p0", 1'b0, 32'd7, 32'd0, 32'hFFFF_FFF0, 1'b1);
    idle();
    expect_uop("addi_neg_p1", 1'b1, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    cycle(1'b1, mk(OP_ADD, 1'b0, 32'h10), 64'd7, 64'd0, 1'b0, 1'b0);
    expect_uop("addi_pos_p0", 1'b0, 32'd7, 32'd0, 32'h10, 1'b1);
    idle();
    expect_uop("addi_pos_p1", 1'b1, 32'd0, 32'd0, 32'h0, 1'b0);
    idle();

    // Stall three cycles in PART_A with a queued instruction behind it.
    i1 = rand_instr();
    i2 = rand_instr();
    cycle(1'b1, i1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    repeat (3) cycle(1'b1, i2, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b1, 1'b0);
    repeat (2) cycle(1'b1, i2, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0, 1'b0);
    idle();
    idle();
    idle();

    // Flush while stalled in PART_A.
    cycle(1'b1, i1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    cycle(1'b1, i2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1);
    idle();
    idle();

    // Three back-to-back instructions.
    repeat (3) cycle(1'b1, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    repeat (4) idle();

    // Asynchronous reset in the middle of PART_B.
    cycle(1'b1, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    idle();
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    reset = 1'b0;
    model_reset();
    idle();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 29) == 0);
      cycle(v, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom}, st, fl);
    end
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
